// File: rtl/dmem_ctrl.sv
// RV32I MEM-stage data memory responder.
// Byte/half/word loads and stores on a word RAM with wait states.
module dmem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  D_MEM_read,
  input  logic                  D_MEM_write,
  input  logic [1:0]            D_MEM_mode,
  input  logic                  D_MEM_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  stall,
  output logic                  misaligned
);
  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [IW-1:0] r_idx;
  logic [1:0]  r_off;
  logic [1:0]  r_mode;
  logic        r_uns;
  logic        r_wr;
  logic        r_err;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req;
  logic        w_illegal;
  logic        w_access;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic        w_unused;

  assign w_unused = ^addr;
  assign w_req    = D_MEM_read | D_MEM_write;
  assign w_illegal = (D_MEM_mode == 2'b11)
                   | (D_MEM_read & D_MEM_write)
                   | ((D_MEM_mode == 2'b01) & addr[0])
                   | ((D_MEM_mode == 2'b10) & (addr[1:0] != 2'b00));
  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_req) w_next = w_illegal ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_off   <= 2'd0;
      r_mode  <= 2'd0;
      r_uns   <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        r_idx   <= addr[IW+1:2];
        r_off   <= addr[1:0];
        r_mode  <= D_MEM_mode;
        r_uns   <= D_MEM_unsigned;
        r_wr    <= D_MEM_write;
        r_wdata <= wdata;
        r_err   <= w_illegal;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !r_wr) r_rdata <= w_ld;
    end
  end

  always_comb begin
    w_be = 4'b1111;
    w_wd = r_wdata;
    unique case (r_mode)
      2'b00: begin
        w_be = 4'b0001 << r_off;
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = r_off[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM is never reset; a reset edge also blocks the pending commit
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  assign w_word = r_mem[r_idx];
  assign w_byte = w_word[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ld = w_word;
    unique case (r_mode)
      2'b00:   w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{~r_uns & w_half[15]}}, w_half};
      default: ;
    endcase
  end

  assign rdata       = r_rdata;
  assign done        = (r_state == S_DONE);
  assign misaligned  = (r_state == S_DONE) & r_err;
  assign rdata_valid = (r_state == S_DONE) & ~r_err & ~r_wr;
  assign stall       = ((r_state == S_IDLE) & w_req)
                     | (r_state == S_BUSY);
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl.
// u0 runs with no wait states, u3 with three.
module tb_dmem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rd0, wr0, un0;
  logic [1:0]  md0;
  logic [31:0] a0, wd0, rdata0;
  logic        rv0, done0, stall0, mis0;

  logic        rst3, rd3, wr3, un3;
  logic [1:0]  md3;
  logic [31:0] a3, wd3, rdata3;
  logic        rv3, done3, stall3, mis3;

  int n_chk = 0;
  int n_err = 0;

  dmem_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst0),
    .D_MEM_read(rd0), .D_MEM_write(wr0),
    .D_MEM_mode(md0), .D_MEM_unsigned(un0),
    .addr(a0), .wdata(wd0),
    .rdata(rdata0), .rdata_valid(rv0),
    .done(done0), .stall(stall0),
    .misaligned(mis0)
  );

  dmem_ctrl #(.WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst3),
    .D_MEM_read(rd3), .D_MEM_write(wr3),
    .D_MEM_mode(md3), .D_MEM_unsigned(un3),
    .addr(a3), .wdata(wd3),
    .rdata(rdata3), .rdata_valid(rv3),
    .done(done3), .stall(stall3),
    .misaligned(mis3)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s3, input bit rd, input bit wr,
                       input logic [1:0] md, input bit un,
                       input logic [31:0] a, input logic [31:0] wd);
    if (s3) begin
      rd3 = rd; wr3 = wr; md3 = md; un3 = un; a3 = a; wd3 = wd;
    end else begin
      rd0 = rd; wr0 = wr; md0 = md; un0 = un; a0 = a; wd0 = wd;
    end
  endtask

  task automatic acc(input bit s3, input bit rd, input bit wr,
                     input logic [1:0] md, input bit un,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output int stl,
                     output logic [31:0] rdv,
                     output logic rv, output logic mis);
    @(negedge clk);
    drive(s3, rd, wr, md, un, a, wd);
    lat = 0;
    stl = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (s3 ? done3 : done0) break;
      stl += int'(s3 ? stall3 : stall0);
      @(negedge clk);
      lat++;
    end
    rdv = s3 ? rdata3 : rdata0;
    rv  = s3 ? rv3 : rv0;
    mis = s3 ? mis3 : mis0;
    if (lat >= 40) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: no done within 40 cycles");
    end
    drive(s3, 0, 0, 2'b00, 0, 32'd0, 32'd0);
  endtask

  int          lat, stl;
  logic [31:0] rdv;
  logic        rv, mis;

  task automatic ld(input bit s3, input logic [1:0] md, input bit un,
                    input logic [31:0] a, input string tag,
                    input logic [31:0] exp);
    acc(s3, 1, 0, md, un, a, 32'd0, lat, stl, rdv, rv, mis);
    check({tag, "_data"}, rdv, exp);
    check({tag, "_rv"}, 32'(rv), 32'd1);
  endtask

  task automatic st(input bit s3, input logic [1:0] md,
                    input logic [31:0] a, input logic [31:0] wd);
    acc(s3, 0, 1, md, 0, a, wd, lat, stl, rdv, rv, mis);
  endtask

  task automatic bad(input bit rd, input bit wr,
                     input logic [1:0] md, input logic [31:0] a,
                     input string tag);
    acc(0, rd, wr, md, 0, a, 32'hFFFF_FFFF, lat, stl, rdv, rv, mis);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_stall"}, 32'(stl), 32'd1);
    check({tag, "_mis"}, 32'(mis), 32'd1);
    check({tag, "_rv"}, 32'(rv), 32'd0);
    check({tag, "_rdata"}, rdv, 32'hDE80_7FEF);
  endtask

  initial begin
    rst0 = 1; rst3 = 1;
    drive(0, 0, 0, 2'b00, 0, 32'd0, 32'd0);
    drive(1, 0, 0, 2'b00, 0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    rst0 = 0; rst3 = 0;
    #1;
    check("rst_done", 32'(done0), 32'd0);
    check("rst_rv", 32'(rv0), 32'd0);
    check("rst_mis", 32'(mis0), 32'd0);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_rdata", rdata0, 32'd0);

    // 1: word store and load, no wait states
    acc(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF,
        lat, stl, rdv, rv, mis);
    check("t1_sw_lat", 32'(lat), 32'd2);
    check("t1_sw_stall", 32'(stl), 32'd2);
    check("t1_sw_rv", 32'(rv), 32'd0);
    check("t1_sw_mis", 32'(mis), 32'd0);
    acc(0, 1, 0, 2'b10, 0, 32'h10, 32'd0, lat, stl, rdv, rv, mis);
    check("t1_lw_lat", 32'(lat), 32'd2);
    check("t1_lw_stall", 32'(stl), 32'd2);
    check("t1_lw_data", rdv, 32'hDEAD_BEEF);
    check("t1_lw_rv", 32'(rv), 32'd1);

    // 2: byte lanes and extension
    st(0, 2'b00, 32'h11, 32'h0000_007F);
    ld(0, 2'b00, 0, 32'h11, "t2_lb11", 32'h0000_007F);
    st(0, 2'b00, 32'h12, 32'h0000_0080);
    ld(0, 2'b00, 0, 32'h12, "t2_lb12", 32'hFFFF_FF80);
    ld(0, 2'b00, 1, 32'h12, "t2_lbu12", 32'h0000_0080);
    ld(0, 2'b10, 0, 32'h10, "t2_lw10", 32'hDE80_7FEF);

    // 3: illegal requests
    bad(1, 0, 2'b01, 32'h13, "t3_lh13");
    bad(0, 1, 2'b10, 32'h12, "t3_sw12");
    bad(1, 0, 2'b11, 32'h10, "t3_mode3");
    bad(1, 1, 2'b10, 32'h10, "t3_rdwr");
    ld(0, 2'b10, 0, 32'h10, "t3_lw10", 32'hDE80_7FEF);

    // 4: three wait states, request held through DONE
    st(1, 2'b10, 32'h20, 32'h1111_2222);
    @(negedge clk);
    drive(1, 1, 0, 2'b10, 0, 32'h20, 32'd0);
    lat = 0; stl = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done3) break;
      stl += int'(stall3);
      @(negedge clk);
      lat++;
    end
    check("t4_lat", 32'(lat), 32'd5);
    check("t4_stall", 32'(stl), 32'd5);
    check("t4_data", rdata3, 32'h1111_2222);
    check("t4_rv", 32'(rv3), 32'd1);
    check("t4_done_stall", 32'(stall3), 32'd0);
    drive(1, 0, 0, 2'b00, 0, 32'd0, 32'd0);
    begin
      int pulses = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        #1;
        pulses += int'(done3);
      end
      check("t4_nodup", 32'(pulses), 32'd0);
    end

    // 5: reset during second BUSY cycle aborts the store
    @(negedge clk);
    drive(1, 0, 1, 2'b10, 0, 32'h20, 32'h1234_5678);
    repeat (2) @(negedge clk);
    rst3 = 1;
    drive(1, 0, 0, 2'b00, 0, 32'd0, 32'd0);
    @(negedge clk);
    rst3 = 0;
    #1;
    check("t5_rdata", rdata3, 32'd0);
    check("t5_done", 32'(done3), 32'd0);
    check("t5_stall", 32'(stall3), 32'd0);
    check("t5_rv", 32'(rv3), 32'd0);
    ld(1, 2'b10, 0, 32'h20, "t5_lw20", 32'h1111_2222);

    // 6: address wrap and halfword extension
    st(0, 2'b10, 32'h1000, 32'hA5A5_A5A5);
    ld(0, 2'b10, 0, 32'h0, "t6_lw0", 32'hA5A5_A5A5);
    ld(0, 2'b01, 1, 32'h2, "t6_lhu2", 32'h0000_A5A5);
    ld(0, 2'b01, 0, 32'h2, "t6_lh2", 32'hFFFF_A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the RV32I pipeline's MEM stage; it consumes the decoder's DMEM controls (D_MEM_read, D_MEM_write, D_MEM_mode) plus the ALU address and rs2 data.
- Performs byte/halfword/word accesses on a word-organised synchronous RAM, with a configurable number of wait states.
- Drives stall to freeze the pipeline while busy and returns sign- or zero-extended load data for WB.
- Flags misaligned or illegal requests instead of performing them.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- WAIT_STATES, 0, extra cycles per access (0..15).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- D_MEM_read  in  1  load request (level, held by the MEM pipeline register).
- D_MEM_write  in  1  store request (level).
- D_MEM_mode  in  2  access width: 00 byte, 01 halfword, 10 word, 11 illegal.
- D_MEM_unsigned  in  1  funct3[2]; 1 means zero-extend the load (LBU/LHU).
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  32  store data (rs2).
- rdata  out  32  extended load data.
- rdata_valid  out  1  one-cycle pulse when a load completes.
- done  out  1  one-cycle pulse when any request completes, including error completions.
- stall  out  1  holds the pipeline; combinational.
- misaligned  out  1  error qualifier, valid with done.

Behaviour:

Reset:
- state=IDLE, wait counter=0, rdata=0.
- rdata_valid, done and misaligned are all 0.
- RAM contents are not reset.
- Reset asserted mid-access aborts the access; a pending store is not committed.

States and transitions:
- IDLE, request = read|write:
  - Legal request: latch addr, wdata, mode and unsigned; counter=WAIT_STATES; go to BUSY.
  - Illegal request: go directly to DONE with the error latched.
- IDLE, no request: remain in IDLE.
- BUSY: if counter==0, perform the access at the clock edge and go to DONE; otherwise decrement the counter.
- DONE: assert done for one cycle; always return to IDLE.
  - Request inputs are ignored in DONE, because the pipeline register still holds the same instruction.
  - This prevents double execution.

Stall and latency:
- stall = (IDLE & request) | BUSY; stall is 0 in DONE.
- Legal access: done is asserted exactly WAIT_STATES+2 cycles after the first request cycle.
- stall is high for WAIT_STATES+2 cycles.

Illegal requests:
- Any of the following is illegal:
  - mode==11.
  - read&write both asserted.
  - halfword with addr[0]=1.
  - word with addr[1:0]!=0.
- Response: no RAM access, misaligned=1 with done, rdata_valid=0, rdata unchanged.
- Error completion is one cycle shorter: stall for 1 cycle, done 1 cycle after the request cycle.

Addressing:
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Higher address bits are ignored, so addresses wrap modulo the depth.

Stores (byte-lane enables, commit at the BUSY→DONE edge):
- byte: lane addr[1:0] ← wdata[7:0].
- halfword: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
- word: all lanes ← wdata.
- Unselected lanes are preserved.

Loads (read at the BUSY→DONE edge):
- Select the byte at addr[1:0], or the half at addr[1].
- Sign-extend when unsigned=0; zero-extend when unsigned=1. Word loads ignore unsigned.
- rdata is registered, presented in DONE with rdata_valid=1, and held until the next completed load.

Ordering:
- A load issued after a store to the same word returns the stored data; there is no bypass hazard because accesses are serialised.

Test Plan:
1. WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 → each request gives stall high for 2 cycles then done; rdata=0xDEADBEEF with rdata_valid.
2. After test 1: SB 0x7F @0x11, then LB @0x11 → rdata=0x0000007F. SB 0x80 @0x12, then LB @0x12 → 0xFFFFFF80. LBU @0x12 → 0x00000080. LW @0x10 → 0xDE807FEF.
3. LH @0x13, SW @0x12, mode=11, and read&write together → each gives done with misaligned=1 after 1 stall cycle; RAM unchanged (LW @0x10 still returns 0xDE807FEF).
4. WAIT_STATES=3: LW held for many cycles → exactly one access; done asserted 5 cycles after request start; stall high for 5 cycles; a new request is accepted only from IDLE.
5. WAIT_STATES=3: SW 0x12345678 @0x20 with rst pulsed in the 2nd BUSY cycle → outputs zero, state IDLE; subsequent LW @0x20 returns the prior contents, not 0x12345678.
6. DEPTH_WORDS=1024: SW 0xA5A5A5A5 @0x1000 (wraps), then LW @0x0 → 0xA5A5A5A5; LHU @0x2 → 0x0000A5A5; LH @0x2 → 0xFFFFA5A5.
